// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoder-side instruction fetch buffer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam int MAX_INST_BYTES = 15;
   localparam int FETCH_BYTES    = 8;

   function automatic logic [63:0] align_down(input logic [63:0] addr);
      return {addr[63:3], 3'b000};
   endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte store: up to 8 bytes pushed and up to 15 popped per cycle,
// with a combinational 15-byte window read at the head.
module fetch_byte_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 32,
   localparam int PW = $clog2(DEPTH),
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          clear_i,
   input  logic [3:0]                    push_cnt_i,
   input  logic [63:0]                   push_data_i,
   input  logic [3:0]                    pop_cnt_i,
   output logic [MAX_INST_BYTES*8-1:0]   window_o,
   output logic [OW-1:0]                 count_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [OW-1:0] count_q, count_d;

   // base + off never reaches 2*DEPTH because off <= 15 and DEPTH >= 24
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input logic [3:0] off);
      logic [PW:0] sum;
      sum = (PW+1)'(base) + (PW+1)'(off);
      if (sum >= (PW+1)'(DEPTH)) begin
         return PW'(sum - (PW+1)'(DEPTH));
      end else begin
         return PW'(sum);
      end
   endfunction

   // pointer and count next-state
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = wrap_idx(head_q, pop_cnt_i);
         tail_d  = wrap_idx(tail_q, push_cnt_i);
         count_d = count_q + OW'(push_cnt_i) - OW'(pop_cnt_i);
      end
   end

   // pointer, count and byte storage registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < FETCH_BYTES; i++) begin
            if ((4'(i) < push_cnt_i) && !clear_i) begin
               mem_q[wrap_idx(tail_q, 4'(i))] <= push_data_i[i*8 +: 8];
            end
         end
      end
   end

   // window read at head
   always_comb begin
      window_o = '0;
      for (int k = 0; k < MAX_INST_BYTES; k++) begin
         window_o[k*8 +: 8] = mem_q[wrap_idx(head_q, 4'(k))];
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/decode_fetch_buffer.sv
// Fetch front end for the x86 decoder: aligned 8-byte fetches with one
// outstanding response, byte queue, 15-byte window and redirect handling.
module decode_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 32,
   parameter logic [63:0] RESET_PC = 64'h0,
   localparam int OW = $clog2(DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush_valid,
   input  logic [63:0]                   flush_addr,
   output logic                          mem_req_valid,
   output logic [63:0]                   mem_req_addr,
   input  logic                          mem_req_ready,
   input  logic                          mem_resp_valid,
   input  logic [63:0]                   mem_resp_data,
   output logic [MAX_INST_BYTES*8-1:0]   buffer,
   output logic [63:0]                   current_addr,
   output logic                          window_valid,
   input  logic                          consume,
   input  logic [3:0]                    byte_incr,
   output logic [OW-1:0]                 occupancy
);

   localparam logic [OW-1:0] REQ_LIMIT = OW'(DEPTH - FETCH_BYTES);

   fetch_state_t state_q, state_d;
   logic [63:0]  fetch_ptr_q, fetch_ptr_d;
   logic [2:0]   skip_q, skip_d;
   logic [63:0]  cur_addr_q, cur_addr_d;

   logic         req_fire_s;
   logic         push_s;
   logic [3:0]   push_cnt_s;
   logic [63:0]  push_data_s;
   logic [3:0]   pop_cnt_s;

   // state and address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         fetch_ptr_q <= align_down(RESET_PC);
         skip_q      <= RESET_PC[2:0];
         cur_addr_q  <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_ptr_q <= fetch_ptr_d;
         skip_q      <= skip_d;
         cur_addr_q  <= cur_addr_d;
      end
   end

   // a flush never cancels an accepted request; its response must be drained in DROP
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_fire_s) begin
               state_d = flush_valid ? DROP : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               state_d = IDLE;
            end else if (flush_valid) begin
               state_d = DROP;
            end else begin
               state_d = WAIT;
            end
         end
         DROP: begin
            if (mem_resp_valid) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state-dependent outputs
   always_comb begin
      mem_req_valid = 1'b0;
      push_s        = 1'b0;
      case (state_q)
         IDLE:    mem_req_valid = !reset && (occupancy <= REQ_LIMIT);
         WAIT:    push_s = mem_resp_valid && !flush_valid;
         DROP:    push_s = 1'b0;
         default: push_s = 1'b0;
      endcase
   end

   assign req_fire_s   = mem_req_valid && mem_req_ready;
   assign window_valid = occupancy >= OW'(MAX_INST_BYTES);
   assign push_cnt_s   = push_s ? (4'(FETCH_BYTES) - {1'b0, skip_q}) : 4'd0;
   assign push_data_s  = mem_resp_data >> {skip_q, 3'b000};
   assign pop_cnt_s    = (consume && window_valid && !flush_valid) ? byte_incr : 4'd0;

   // fetch pointer, skip and current address next-state
   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      skip_d      = skip_q;
      cur_addr_d  = cur_addr_q;
      if (flush_valid) begin
         fetch_ptr_d = align_down(flush_addr);
         skip_d      = flush_addr[2:0];
         cur_addr_d  = flush_addr;
      end else begin
         if (push_s) begin
            fetch_ptr_d = fetch_ptr_q + 64'(FETCH_BYTES);
            skip_d      = 3'd0;
         end else begin
            fetch_ptr_d = fetch_ptr_q;
            skip_d      = skip_q;
         end
         cur_addr_d = cur_addr_q + 64'(pop_cnt_s);
      end
   end

   assign mem_req_addr = fetch_ptr_q;
   assign current_addr = cur_addr_q;

   fetch_byte_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i       (clk),
      .reset_i     (reset),
      .clear_i     (flush_valid),
      .push_cnt_i  (push_cnt_s),
      .push_data_i (push_data_s),
      .pop_cnt_i   (pop_cnt_s),
      .window_o    (buffer),
      .count_o     (occupancy)
   );

endmodule

// File: tb/tb_decode_fetch_buffer.sv
// Directed bench for decode_fetch_buffer; memory returns byte value addr[7:0]
// so the expected byte stream is known from the fetch address alone.
module tb_decode_fetch_buffer;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_valid;
   logic [63:0]   flush_addr;
   logic          mem_req_valid;
   logic [63:0]   mem_req_addr;
   logic          mem_req_ready;
   logic          mem_resp_valid;
   logic [63:0]   mem_resp_data;
   logic [119:0]  buffer;
   logic [63:0]   current_addr;
   logic          window_valid;
   logic          consume;
   logic [3:0]    byte_incr;
   logic [5:0]    occupancy;

   int            n_checks = 0;
   int            n_fail   = 0;
   byte unsigned  exp_q[$];
   logic [63:0]   exp_cur;
   logic [63:0]   req_addr_r;

   always #5 clk = ~clk;

   decode_fetch_buffer #(.DEPTH(32), .RESET_PC(64'h400000)) dut (
      .clk            (clk),
      .reset          (reset),
      .flush_valid    (flush_valid),
      .flush_addr     (flush_addr),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .buffer         (buffer),
      .current_addr   (current_addr),
      .window_valid   (window_valid),
      .consume        (consume),
      .byte_incr      (byte_incr),
      .occupancy      (occupancy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_window(input string tag);
      int n;
      chk({tag, "_occ"}, 64'(occupancy), 64'(exp_q.size()));
      chk({tag, "_wv"}, 64'(window_valid), (exp_q.size() >= 15) ? 64'd1 : 64'd0);
      chk({tag, "_cur"}, current_addr, exp_cur);
      n = (exp_q.size() < 15) ? exp_q.size() : 15;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("%s_b%0d", tag, k), 64'(buffer[k*8 +: 8]), 64'(exp_q[k]));
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [63:0] addr);
      logic [63:0] d;
      for (int i = 0; i < 8; i++) begin
         d[i*8 +: 8] = addr[7:0] + 8'(i);
      end
      return d;
   endfunction

   task automatic pop_model(input int n, input bit was_valid);
      byte unsigned dummy;
      if (was_valid) begin
         for (int i = 0; i < n; i++) begin
            dummy = exp_q.pop_front();
         end
         exp_cur = exp_cur + 64'(n);
      end
   endtask

   task automatic do_request(input string tag, input logic [63:0] exp_addr, input int hold);
      int waited = 0;
      while (!mem_req_valid && waited < 20) begin
         tick();
         waited++;
      end
      chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk($sformatf("%s_hold%0d_valid", tag, i), 64'(mem_req_valid), 64'd1);
         chk($sformatf("%s_hold%0d_addr", tag, i), mem_req_addr, exp_addr);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      req_addr_r = exp_addr;
   endtask

   task automatic respond(input int skip, input bit push, input int cons);
      logic [63:0] d;
      bit          was_valid;
      d = mem_word(req_addr_r);
      mem_resp_data  = d;
      mem_resp_valid = 1'b1;
      if (cons > 0) begin
         consume   = 1'b1;
         byte_incr = 4'(cons);
      end
      was_valid = exp_q.size() >= 15;
      tick();
      mem_resp_valid = 1'b0;
      consume        = 1'b0;
      if (cons > 0) pop_model(cons, was_valid);
      if (push) begin
         for (int i = skip; i < 8; i++) exp_q.push_back(d[i*8 +: 8]);
      end
   endtask

   task automatic consume_step(input int n);
      bit was_valid;
      was_valid = exp_q.size() >= 15;
      consume   = 1'b1;
      byte_incr = 4'(n);
      tick();
      consume = 1'b0;
      pop_model(n, was_valid);
   endtask

   task automatic flush_step(input logic [63:0] addr, input bit with_resp);
      flush_valid = 1'b1;
      flush_addr  = addr;
      if (with_resp) begin
         mem_resp_data  = mem_word(req_addr_r);
         mem_resp_valid = 1'b1;
      end
      tick();
      flush_valid    = 1'b0;
      mem_resp_valid = 1'b0;
      exp_q.delete();
      exp_cur = addr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush_valid = 1'b0; flush_addr = 64'd0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
      consume = 1'b0; byte_incr = 4'd0;
      exp_cur = 64'h400000; req_addr_r = 64'd0;
      tick(); tick();
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_cur", current_addr, 64'h400000);
      chk("rst_wv", 64'(window_valid), 64'd0);
      chk("rst_buf_lo", buffer[63:0], 64'd0);
      chk("rst_buf_hi", 64'(buffer[119:64]), 64'd0);
      chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
      reset = 1'b0;

      // two aligned fetches fill the window
      do_request("t1a", 64'h400000, 0);
      respond(0, 1'b1, 0);
      do_request("t1b", 64'h400008, 0);
      respond(0, 1'b1, 0);
      check_window("t1");

      // retire 3, window drops; consume while invalid is ignored
      consume_step(3);
      check_window("t2");
      consume_step(4);
      check_window("t2_ign");
      do_request("t2c", 64'h400010, 4);
      respond(0, 1'b1, 0);
      check_window("t2_refill");

      // unaligned redirect with the pending request not accepted
      flush_step(64'h400105, 1'b0);
      check_window("t3_flush");
      chk("t3_next_req_valid", 64'(mem_req_valid), 64'd1);
      do_request("t3", 64'h400100, 0);
      respond(5, 1'b1, 0);
      check_window("t3");

      // redirect while waiting: the late response is stale
      do_request("t4a", 64'h400108, 0);
      flush_step(64'h400200, 1'b0);
      chk("t4_drop_no_req", 64'(mem_req_valid), 64'd0);
      respond(0, 1'b0, 0);
      check_window("t4_discard");
      do_request("t4b", 64'h400200, 0);
      respond(0, 1'b1, 0);
      do_request("t4c", 64'h400208, 0);
      respond(0, 1'b1, 0);
      check_window("t4");

      // push and pop on the same edge
      do_request("t5", 64'h400210, 0);
      respond(0, 1'b1, 5);
      check_window("t5");

      // request throttling near full, queue wraps
      do_request("t6a", 64'h400218, 0);
      respond(0, 1'b1, 0);
      chk("t6_full_no_req0", 64'(mem_req_valid), 64'd0);
      tick();
      chk("t6_full_no_req1", 64'(mem_req_valid), 64'd0);
      consume_step(3);
      check_window("t6_24");
      chk("t6_req_at_24", 64'(mem_req_valid), 64'd1);
      do_request("t6b", 64'h400220, 0);
      respond(0, 1'b1, 0);
      check_window("t6_32");
      chk("t6_no_req_at_32", 64'(mem_req_valid), 64'd0);
      consume_step(15);
      check_window("t6_wrap17");
      consume_step(15);
      check_window("t6_wrap2");

      // redirect in the same cycle the response arrives
      do_request("t7a", 64'h400228, 0);
      flush_step(64'h400333, 1'b1);
      check_window("t7_flush");
      chk("t7_req_valid", 64'(mem_req_valid), 64'd1);
      chk("t7_req_addr", mem_req_addr, 64'h400330);
      do_request("t7b", 64'h400330, 0);
      respond(3, 1'b1, 0);
      check_window("t7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
